// File: rtl/angle_resolver_pkg.sv
// Shared constants, types and helpers for the angle resolver.
// Contents: angle index geometry (PICK_BASE, QUAD_LEN, LUT_DEPTH), quadrant and
// FSM state enums, quadrant base address, sin-port address fold, absolute
// difference of two products.
package angle_resolver_pkg;

    localparam int unsigned PICK_BASE = 32;
    localparam int unsigned QUAD_LEN  = 112;
    localparam int unsigned LUT_DEPTH = 448;

    localparam logic [19:0] ERR_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SWEEP = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // First LUT address of a quadrant (q * QUAD_LEN).
    function automatic logic [8:0] quad_base(input quad_t q);
        logic [8:0] base;
        case (q)
            Q0:      base = 9'd0;
            Q1:      base = 9'd112;
            Q2:      base = 9'd224;
            Q3:      base = 9'd336;
            default: base = 9'd0;
        endcase
        return base;
    endfunction

    // The sin port reads a quarter turn ahead of the cos port, wrapping at LUT_DEPTH.
    function automatic logic [8:0] sin_addr(input logic [8:0] k);
        logic [8:0] a;
        if (k >= 9'd336) begin
            a = k - 9'd336;
        end else begin
            a = k + 9'd112;
        end
        return a;
    endfunction

    // |a - b| for two unsigned 20-bit products; equivalent to abs of the 21-bit signed difference.
    function automatic logic [19:0] abs_diff(input logic [19:0] a, input logic [19:0] b);
        logic [19:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/angle_resolver_if.sv
// Request/response bundle of the angle resolver.
// start, centerX/Y, PointX/Y : requester -> resolver
// busy, done, valid, PickY   : resolver -> requester
interface angle_resolver_if;
    logic       start;
    logic [9:0] centerX;
    logic [9:0] centerY;
    logic [9:0] PointX;
    logic [9:0] PointY;
    logic       busy;
    logic       done;
    logic       valid;
    logic [9:0] PickY;

    modport master (
        output start, centerX, centerY, PointX, PointY,
        input  busy, done, valid, PickY
    );

    modport slave (
        input  start, centerX, centerY, PointX, PointY,
        output busy, done, valid, PickY
    );
endinterface

// File: rtl/angle_resolver_argmin.sv
// Running minimum over (err, addr) pairs.
// clr loads best_err=all ones and best_addr=clr_addr; en offers one pair per cycle.
// Strict less-than keeps the earliest (lowest) address on ties.
// Ports: clk, rst_n (sync, active-low), clr, clr_addr, en, err, addr, best_addr.
module angle_argmin
    import angle_resolver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [8:0]  clr_addr,
    input  logic        en,
    input  logic [19:0] err,
    input  logic [8:0]  addr,
    output logic [8:0]  best_addr
);

    logic [19:0] best_err_q;
    logic [19:0] best_err_d;
    logic [8:0]  best_addr_q;
    logic [8:0]  best_addr_d;

    // Clear has priority over a candidate offered in the same cycle.
    always_comb begin
        best_err_d  = best_err_q;
        best_addr_d = best_addr_q;
        if (clr) begin
            best_err_d  = ERR_MAX;
            best_addr_d = clr_addr;
        end else if (en && (err < best_err_q)) begin
            best_err_d  = err;
            best_addr_d = addr;
        end else begin
            best_err_d  = best_err_q;
            best_addr_d = best_addr_q;
        end
    end

    // Minimum registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_err_q  <= ERR_MAX;
            best_addr_q <= 9'd0;
        end else begin
            best_err_q  <= best_err_d;
            best_addr_q <= best_addr_d;
        end
    end

    assign best_addr = best_addr_q;

endmodule

// File: rtl/angle_resolver_trig_lut.sv
// Trigonometric ROM: 448 entries of round(1023*|cos(2*pi*i/448)|), one-cycle registered read.
// Magnitudes only; the resolver works on |dx|,|dy| within a quadrant so signs are not needed.
// Ports: clk, addr (9b, out-of-range reads return 0), data (10b, valid the cycle after addr).
module trig_lut
    import angle_resolver_pkg::*;
(
    input  logic       clk,
    input  logic [8:0] addr,
    output logic [9:0] data
);

    // cos over the first quarter turn (j = 0..112), fixed-point Taylor series to x^12.
    function automatic logic [9:0] quarter_cos(input int j);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint val;
        x    = (longint'(j) * 64'sd3373259426) / 64'sd224;   // j*pi/224 in Q30
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int n = 1; n <= 6; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n)));
            sum  = sum + term;
        end
        if (sum < 64'sd0) begin
            sum = 64'sd0;
        end else begin
            sum = sum;
        end
        val = (sum * 64'sd1023 + (64'sd1 <<< 29)) >>> 30;
        if (val > 64'sd1023) begin
            val = 64'sd1023;
        end else begin
            val = val;
        end
        return val[9:0];
    endfunction

    // |cos| is periodic in half a turn and symmetric about the quarter turn.
    function automatic logic [9:0] abs_cos_code(input int idx);
        int r;
        int j;
        r = idx % 224;
        if (r <= 112) begin
            j = r;
        end else begin
            j = 224 - r;
        end
        return quarter_cos(j);
    endfunction

    logic [9:0] rom_s [LUT_DEPTH];
    logic [9:0] data_d;
    logic [9:0] data_q;

    for (genvar g = 0; g < int'(LUT_DEPTH); g++) begin : g_rom
        localparam logic [9:0] ROM_VAL = abs_cos_code(g);
        assign rom_s[g] = ROM_VAL;
    end

    // ROM read with guard for addresses beyond the table.
    always_comb begin
        data_d = 10'd0;
        if (addr < 9'(LUT_DEPTH)) begin
            data_d = rom_s[addr];
        end else begin
            data_d = 10'd0;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/angle_resolver.sv
// Angle resolver: finds the angle index PickY (32..479) whose rotated position lies on the
// ray centre->point, by sweeping one quadrant of the trig ROM and keeping the best match.
// Ports: CLK, Reset_n (sync, active-low), bus (slave): start, centerX/Y, PointX/Y in;
//        busy, done (1-cycle pulse), valid (sticky), PickY out. All outputs registered.
// Fixed latency: start sampled at edge 0, done high after edge 116.
module angle_resolver
    import angle_resolver_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset_n,
    angle_resolver_if.slave  bus
);

    state_t      state_q, state_d;
    logic [9:0]  cx_q, cx_d, cy_q, cy_d, px_q, px_d, py_q, py_d;
    logic [9:0]  adx_q, adx_d, ady_q, ady_d;
    logic        zero_q, zero_d;
    logic [8:0]  addr_q, addr_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        drain_q, drain_d;
    // compare pipeline: stage 1 = LUT data present, stage 2 = err registered
    logic        v1_q, v1_d, v2_q, v2_d;
    logic [8:0]  k1_q, k1_d, k2_q, k2_d;
    logic [19:0] err_q, err_d;
    logic        busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [9:0]  pick_q, pick_d;

    logic signed [10:0] dx_s, dy_s;
    quad_t       quad_s;
    logic        clr_s;
    logic [8:0]  clr_addr_s;
    logic [8:0]  sin_k_s;
    logic [9:0]  cos_s, sin_s;
    logic [19:0] prod_c_s, prod_s_s;
    logic [8:0]  best_addr_s;

    trig_lut u_cos_lut (.clk(CLK), .addr(addr_q),  .data(cos_s));
    trig_lut u_sin_lut (.clk(CLK), .addr(sin_k_s), .data(sin_s));

    angle_argmin u_argmin (
        .clk       (CLK),
        .rst_n     (Reset_n),
        .clr       (clr_s),
        .clr_addr  (clr_addr_s),
        .en        (v2_q),
        .err       (err_q),
        .addr      (k2_q),
        .best_addr (best_addr_s)
    );

    // Next-state, datapath and output logic.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        px_d    = px_q;
        py_d    = py_q;
        adx_d   = adx_q;
        ady_d   = ady_q;
        zero_d  = zero_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        pick_d  = pick_q;
        quad_s  = Q0;
        clr_s   = 1'b0;

        sin_k_s  = sin_addr(addr_q);
        dx_s     = signed'({1'b0, px_q}) - signed'({1'b0, cx_q});
        dy_s     = signed'({1'b0, py_q}) - signed'({1'b0, cy_q});
        prod_c_s = {10'd0, ady_q} * {10'd0, cos_s};
        prod_s_s = {10'd0, adx_q} * {10'd0, sin_s};

        v1_d  = 1'b0;
        k1_d  = addr_q;
        v2_d  = v1_q;
        k2_d  = k1_q;
        err_d = abs_diff(prod_c_s, prod_s_s);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cx_d    = bus.centerX;
                    cy_d    = bus.centerY;
                    px_d    = bus.PointX;
                    py_d    = bus.PointY;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                // sign bits of dx,dy pick the quadrant; dx=0 or dy=0 count as non-negative
                case ({dx_s[10], dy_s[10]})
                    2'b00:   quad_s = Q0;
                    2'b10:   quad_s = Q1;
                    2'b11:   quad_s = Q2;
                    2'b01:   quad_s = Q3;
                    default: quad_s = Q0;
                endcase
                adx_d   = dx_s[10] ? 10'(-dx_s) : dx_s[9:0];
                ady_d   = dy_s[10] ? 10'(-dy_s) : dy_s[9:0];
                zero_d  = (dx_s == 11'sd0) && (dy_s == 11'sd0);
                addr_d  = quad_base(quad_s);
                cnt_d   = 7'd0;
                clr_s   = 1'b1;
                state_d = S_SWEEP;
            end
            S_SWEEP: begin
                v1_d = 1'b1;
                k1_d = addr_q;
                if (cnt_q == 7'd111) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d  = addr_q + 9'd1;
                    cnt_d   = cnt_q + 7'd1;
                    state_d = S_SWEEP;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (zero_q) begin
                    pick_d = 10'(PICK_BASE);
                end else begin
                    pick_d = {1'b0, best_addr_s} + 10'(PICK_BASE);
                end
                done_d  = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        clr_addr_s = quad_base(quad_s);
    end

    // State, pipeline and output registers.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cx_q    <= 10'd0;
            cy_q    <= 10'd0;
            px_q    <= 10'd0;
            py_q    <= 10'd0;
            adx_q   <= 10'd0;
            ady_q   <= 10'd0;
            zero_q  <= 1'b0;
            addr_q  <= 9'd0;
            cnt_q   <= 7'd0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            k1_q    <= 9'd0;
            v2_q    <= 1'b0;
            k2_q    <= 9'd0;
            err_q   <= 20'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            pick_q  <= 10'(PICK_BASE);
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            adx_q   <= adx_d;
            ady_q   <= ady_d;
            zero_q  <= zero_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            v1_q    <= v1_d;
            k1_q    <= k1_d;
            v2_q    <= v2_d;
            k2_q    <= k2_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            pick_q  <= pick_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.valid = valid_q;
    assign bus.PickY = pick_q;

endmodule

// File: tb/tb_angle_resolver.sv
module tb_angle_resolver;

    logic CLK = 1'b0;
    logic Reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    angle_resolver_if bus ();

    angle_resolver dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    // Forward rotation of index p (32..479) at radius 100 around (cx,cy).
    task automatic set_point(input int cx, input int cy, input int p);
        real th;
        int  dx;
        int  dy;
        th = 2.0 * 3.14159265358979 * real'(p - 32) / 448.0;
        dx = int'(100.0 * $cos(th));
        dy = int'(100.0 * $sin(th));
        bus.centerX = 10'(cx);
        bus.centerY = 10'(cy);
        bus.PointX  = 10'(cx + dx);
        bus.PointY  = 10'(cy + dy);
    endtask

    // Pulse start (edge 0), then watch 130 edges. Optional restart pulse / reset at given edges.
    task automatic run_op(input int repulse_at, input int new_px, input int reset_at,
                          output int done_edge, output int done_cnt,
                          output logic [9:0] pick, output logic busy_at_done);
        done_edge    = -1;
        done_cnt     = 0;
        pick         = 10'd0;
        busy_at_done = 1'b1;
        bus.start = 1'b1;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b expected 1", bus.busy);
        end
        for (int n = 1; n <= 130; n++) begin
            if (n == repulse_at) begin
                bus.start  = 1'b1;
                bus.PointX = 10'(new_px);
            end else begin
                bus.start = 1'b0;
            end
            Reset_n = (reset_at != 0 && n == reset_at) ? 1'b0 : 1'b1;
            @(posedge CLK);
            #1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge    = n;
                    pick         = bus.PickY;
                    busy_at_done = bus.busy;
                end
            end
            if (reset_at != 0 && n == reset_at) begin
                tests++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_mid_busy_done: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
                end
            end
        end
        bus.start = 1'b0;
        Reset_n   = 1'b1;
    endtask

    function automatic bit near(input logic [9:0] pick, input int p);
        int d;
        d = (int'(pick) - p + 448) % 448;
        return (d == 0) || (d == 1) || (d == 447);
    endfunction

    task automatic test_reset();
        bus.start = 1'b0;
        set_point(320, 240, 32);
        Reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (bus.PickY !== 10'd32) begin fails++; $display("FAIL reset_pick: got %0d expected 32", bus.PickY); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++;
        if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++;
        if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        Reset_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_basic();
        int e, c;
        logic [9:0] pk;
        logic b;
        bus.centerX = 10'd320; bus.centerY = 10'd240;
        bus.PointX  = 10'd420; bus.PointY  = 10'd240;
        run_op(0, 0, 0, e, c, pk, b);
        tests++;
        if (e != 116) begin fails++; $display("FAIL basic_latency: got %0d expected 116", e); end
        tests++;
        if (c != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", c); end
        tests++;
        if (pk !== 10'd32) begin fails++; $display("FAIL basic_pick: got %0d expected 32", pk); end
        tests++;
        if (b !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b expected 0", b); end
        tests++;
        if (bus.valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", bus.valid); end
    endtask

    task automatic test_round_trip();
        int plist[11] = '{32, 100, 143, 144, 200, 255, 256, 300, 367, 368, 479};
        int e, c;
        logic [9:0] pk;
        logic b;
        foreach (plist[i]) begin
            set_point(320, 240, plist[i]);
            run_op(0, 0, 0, e, c, pk, b);
            tests++;
            if (e != 116 || c != 1) begin
                fails++;
                $display("FAIL rt_timing P=%0d: got edge %0d count %0d expected 116 1", plist[i], e, c);
            end
            tests++;
            if (!near(pk, plist[i])) begin
                fails++;
                $display("FAIL rt_pick: got %0d expected %0d+-1", pk, plist[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        int e, c;
        logic [9:0] pk;
        logic b;
        bus.centerX = 10'd200; bus.centerY = 10'd200;
        bus.PointX  = 10'd200; bus.PointY  = 10'd200;
        run_op(0, 0, 0, e, c, pk, b);
        tests++;
        if (e != 116) begin fails++; $display("FAIL degen_latency: got %0d expected 116", e); end
        tests++;
        if (pk !== 10'd32) begin fails++; $display("FAIL degen_pick: got %0d expected 32", pk); end
        tests++;
        if (bus.valid !== 1'b1) begin fails++; $display("FAIL degen_valid: got %b expected 1", bus.valid); end
    endtask

    task automatic test_restart_ignored();
        int e, c;
        logic [9:0] pk;
        logic b;
        set_point(320, 240, 100);
        run_op(50, 100, 0, e, c, pk, b);
        tests++;
        if (c != 1) begin fails++; $display("FAIL restart_done_count: got %0d expected 1", c); end
        tests++;
        if (e != 116) begin fails++; $display("FAIL restart_latency: got %0d expected 116", e); end
        tests++;
        if (!near(pk, 100)) begin fails++; $display("FAIL restart_pick: got %0d expected 100+-1", pk); end
    endtask

    task automatic test_reset_mid_op();
        int e, c;
        logic [9:0] pk;
        logic b;
        set_point(320, 240, 200);
        run_op(0, 0, 60, e, c, pk, b);
        tests++;
        if (c != 0) begin fails++; $display("FAIL midreset_done_count: got %0d expected 0", c); end
        tests++;
        if (bus.valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", bus.valid); end
        tests++;
        if (bus.PickY !== 10'd32) begin fails++; $display("FAIL midreset_pick: got %0d expected 32", bus.PickY); end
        set_point(320, 240, 300);
        run_op(0, 0, 0, e, c, pk, b);
        tests++;
        if (e != 116 || c != 1) begin
            fails++;
            $display("FAIL fresh_timing: got edge %0d count %0d expected 116 1", e, c);
        end
        tests++;
        if (!near(pk, 300)) begin fails++; $display("FAIL fresh_pick: got %0d expected 300+-1", pk); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_basic();
        test_round_trip();
        test_degenerate();
        test_restart_ignored();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
